// File: rtl/iq_pkg.sv
// Shared types and sizing for the instruction-queue dispatch controller.
package iq_pkg;

    localparam int unsigned IQ_DEPTH = 16;
    localparam int unsigned IQ_OCC_W = $clog2(IQ_DEPTH) + 1;
    localparam int unsigned IQ_INS_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } iq_state_e;

    // One staging slot: valid bit plus instruction payload
    typedef struct packed {
        logic                vld;
        logic [IQ_INS_W-1:0] ins;
    } stage_slot_t;

endpackage

// File: rtl/popcount4.sv
// Counts the asserted bits of a 4-bit vector (used for per-cycle dequeue count).
module popcount4 (
    input  logic [3:0] bits,
    output logic [2:0] cnt
);

    // Sum of the four single-bit terms
    always_comb begin
        cnt = 3'(bits[0]) + 3'(bits[1]) + 3'(bits[2]) + 3'(bits[3]);
    end

endmodule

// File: rtl/iq_dispatch_ctrl.sv
// Dispatch controller between decode and the instruction queue. Stages up to one
// pair from decode and releases it in program order as queue occupancy allows.
module iq_dispatch_ctrl
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned INS_W = IQ_INS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_vld_1,
    input  logic                   dec_vld_2,
    input  logic [INS_W-1:0]       dec_ins_1,
    input  logic [INS_W-1:0]       dec_ins_2,
    output logic                   dec_rdy,
    input  logic                   iq_deq_1,
    input  logic                   iq_deq_2,
    input  logic                   iq_deq_3,
    input  logic                   iq_deq_4,
    input  logic                   flush,
    output logic                   ins_new_1_vld,
    output logic                   ins_new_2_vld,
    output logic [INS_W-1:0]       ins_new_1_data,
    output logic [INS_W-1:0]       ins_new_2_data,
    output logic [$clog2(DEPTH):0] iq_occ,
    output logic                   iq_full,
    output logic                   occ_err
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = OCC_W + 1;

    iq_state_e         state_q;
    stage_slot_t       s1_q, s2_q;
    stage_slot_t       s1_d, s2_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              err_q, err_d;

    logic [2:0]        deq_cnt;
    logic [1:0]        buf_cnt;
    logic [1:0]        lim;
    logic [1:0]        n_disp;
    logic [OCC_W-1:0]  free;
    logic [SUM_W-1:0]  occ_sum;
    logic              accept;

    popcount4 u_deq_cnt (
        .bits ({iq_deq_4, iq_deq_3, iq_deq_2, iq_deq_1}),
        .cnt  (deq_cnt)
    );

    // Dispatch count: limited by buffered entries, free queue space and port width.
    // Free space uses the registered occupancy only; same-cycle dequeues are not credited.
    always_comb begin
        buf_cnt = {1'b0, s1_q.vld} + {1'b0, s2_q.vld};
        free    = OCC_W'(DEPTH) - occ_q;
        lim     = (free >= OCC_W'(2)) ? 2'd2 : free[1:0];
        if (flush) begin
            n_disp = 2'd0;
        end else begin
            n_disp = (buf_cnt < lim) ? buf_cnt : lim;
        end
    end

    // Decode handshake: a new pair is taken only if the whole buffer drains this cycle
    always_comb begin
        dec_rdy = 1'b0;
        unique case (state_q)
            IDLE:    dec_rdy = 1'b1;
            HOLD:    dec_rdy = (n_disp == buf_cnt);
            FLUSH:   dec_rdy = 1'b0;
            default: dec_rdy = 1'b0;
        endcase
        if (flush) begin
            dec_rdy = 1'b0;
        end
    end

    assign accept = dec_rdy & dec_vld_1;

    // Dispatch strobes and payloads come straight from the staging slots
    always_comb begin
        ins_new_1_vld  = (n_disp != 2'd0);
        ins_new_2_vld  = (n_disp == 2'd2);
        ins_new_1_data = INS_W'(s1_q.ins);
        ins_new_2_data = INS_W'(s2_q.ins);
    end

    // Next slot contents after this cycle's dispatch, accept or flush
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (flush) begin
            s1_d = '0;
            s2_d = '0;
        end else if (accept) begin
            // Accept implies everything staged leaves this cycle, so both slots are free
            s1_d.vld = 1'b1;
            s1_d.ins = IQ_INS_W'(dec_ins_1);
            s2_d.vld = dec_vld_2;
            s2_d.ins = dec_vld_2 ? IQ_INS_W'(dec_ins_2) : '0;
        end else if (n_disp == buf_cnt) begin
            s1_d = '0;
            s2_d = '0;
        end else if (n_disp == 2'd1) begin
            // Partial dispatch: the younger entry becomes the oldest
            s1_d = s2_q;
            s2_d = '0;
        end
    end

    // Occupancy bookkeeping with sticky underflow detection
    always_comb begin
        occ_sum = SUM_W'(occ_q) + SUM_W'(n_disp);
        err_d   = err_q;
        occ_d   = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (occ_sum < SUM_W'(deq_cnt)) begin
            occ_d = '0;
            err_d = 1'b1;
        end else begin
            occ_d = OCC_W'(occ_sum - SUM_W'(deq_cnt));
        end
    end

    // Controller FSM and staging slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            if (flush) begin
                state_q <= FLUSH;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) state_q <= HOLD;
                    end
                    HOLD: begin
                        if (!s1_d.vld) state_q <= IDLE;
                    end
                    FLUSH:   state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Occupancy counter and sticky error flag; only reset clears the error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
            err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            err_q <= err_d;
        end
    end

    assign iq_occ  = occ_q;
    assign iq_full = (occ_q == OCC_W'(DEPTH));
    assign occ_err = err_q;

endmodule
